// File: rtl/video_ts_render_if.sv
// ---------------------------------------------------------------------------
// video_ts_render_if
// Bundles every non-clock signal of the tile/sprite line renderer.
//   Task side : start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs,
//               tsr_xf, tsr_pal in; tsr_rdy out
//   DRAM side : dram_addr, dram_req out; dram_next, dram_rdata in
//   Line buf  : ts_waddr, ts_wdata, ts_we out
// The slave modport is the renderer's view; master is the driver/bench view.
// ---------------------------------------------------------------------------
interface video_ts_render_if;
  logic        start;
  logic        tsr_go;
  logic [5:0]  tsr_addr;
  logic [8:0]  tsr_line;
  logic [7:0]  tsr_page;
  logic [8:0]  tsr_x;
  logic [2:0]  tsr_xs;
  logic        tsr_xf;
  logic [3:0]  tsr_pal;
  logic        tsr_rdy;

  logic [20:0] dram_addr;
  logic        dram_req;
  logic        dram_next;
  logic [15:0] dram_rdata;

  logic [8:0]  ts_waddr;
  logic [7:0]  ts_wdata;
  logic        ts_we;

  modport slave (
    input  start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs,
           tsr_xf, tsr_pal, dram_next, dram_rdata,
    output tsr_rdy, dram_addr, dram_req, ts_waddr, ts_wdata, ts_we
  );

  modport master (
    output start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs,
           tsr_xf, tsr_pal, dram_next, dram_rdata,
    input  tsr_rdy, dram_addr, dram_req, ts_waddr, ts_wdata, ts_we
  );
endinterface

// File: rtl/video_ts_render.sv
// ---------------------------------------------------------------------------
// video_ts_render
// Renders one tile/sprite strip of a bitmap line into the line buffer.
// A task (accepted while tsr_rdy=1) names a bitmap page/line, a starting
// word-pair index, a line-buffer x position, a width of (xs+1)*8 pixels,
// an optional X flip and a palette nibble. The block fetches (xs+1)*2
// 16-bit words from DRAM, one at a time, and writes each word's four
// 4-bit pixels on four consecutive cycles; index 0 is transparent.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : video_ts_render_if.slave (task, DRAM and line-buffer signals)
// ---------------------------------------------------------------------------
module video_ts_render (
  input  logic             clk,
  input  logic             rst,
  video_ts_render_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [5:0]  r_addr;
  logic [8:0]  r_line;
  logic [7:0]  r_page;
  logic [8:0]  r_x;
  logic [2:0]  r_xs;
  logic        r_xf;
  logic [3:0]  r_pal;
  logic [15:0] r_word;
  logic [3:0]  r_w;
  logic [6:0]  r_p;
  logic [1:0]  r_sub;

  logic        w_accept;
  logic        w_lastWord;
  logic [3:0]  w_lastIdx;
  logic [3:0]  w_offset;
  logic [6:0]  w_col;
  logic [7:0]  w_pageSum;
  logic [1:0]  w_slot;
  logic [3:0]  w_nibble;
  logic        w_rdy;
  logic        w_req;
  logic        w_draw;

  // A task is taken only from IDLE and never in the same cycle as start.
  assign w_accept   = (r_state == ST_IDLE) && bus.tsr_go && !bus.start;

  // The last word index is N-1 = 2*xs+1, which is just xs with a 1 appended.
  assign w_lastIdx  = {r_xs, 1'b1};
  assign w_lastWord = (r_w == w_lastIdx);

  // Flipped strips walk the bitmap words backwards; the column sum wraps
  // inside the 128-word bitmap line and the page carry wraps at 256.
  assign w_offset   = r_xf ? (w_lastIdx - r_w) : r_w;
  assign w_col      = {r_addr, 1'b0} + {3'b000, w_offset};
  assign w_pageSum  = r_page + {5'b00000, r_line[8:6]};

  // Unflipped pixel order is [7:4],[3:0],[15:12],[11:8]; flipping simply
  // walks the same slot list from the far end, so the slot is ~sub.
  assign w_slot     = r_xf ? ~r_sub : r_sub;

  // Select the nibble for the current draw slot.
  always_comb begin
    w_nibble = 4'h0;
    case (w_slot)
      2'd0:    w_nibble = r_word[7:4];
      2'd1:    w_nibble = r_word[3:0];
      2'd2:    w_nibble = r_word[15:12];
      default: w_nibble = r_word[11:8];
    endcase
  end

  // Next-state and state-decoded outputs. start overrides everything and
  // parks the machine in IDLE on the following cycle.
  always_comb begin
    w_stateNext = r_state;
    w_rdy       = 1'b0;
    w_req       = 1'b0;
    w_draw      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rdy = 1'b1;
        if (bus.tsr_go) begin
          w_stateNext = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_req = 1'b1;
        if (bus.dram_next) begin
          w_stateNext = ST_DRAW;
        end
      end
      ST_DRAW: begin
        w_draw = 1'b1;
        if (r_sub == 2'd3) begin
          w_stateNext = w_lastWord ? ST_IDLE : ST_FETCH;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
    if (bus.start) begin
      w_stateNext = ST_IDLE;
    end
  end

  // State register, task latch, fetched word and the word/pixel counters.
  // The counters only move while drawing and freeze on an abort; the next
  // accepted task clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_line  <= '0;
      r_page  <= '0;
      r_x     <= '0;
      r_xs    <= '0;
      r_xf    <= 1'b0;
      r_pal   <= '0;
      r_word  <= '0;
      r_w     <= '0;
      r_p     <= '0;
      r_sub   <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_addr <= bus.tsr_addr;
        r_line <= bus.tsr_line;
        r_page <= bus.tsr_page;
        r_x    <= bus.tsr_x;
        r_xs   <= bus.tsr_xs;
        r_xf   <= bus.tsr_xf;
        r_pal  <= bus.tsr_pal;
        r_w    <= '0;
        r_p    <= '0;
        r_sub  <= '0;
      end
      if ((r_state == ST_FETCH) && bus.dram_next && !bus.start) begin
        r_word <= bus.dram_rdata;
      end
      if ((r_state == ST_DRAW) && !bus.start) begin
        r_sub <= r_sub + 2'd1;
        r_p   <= r_p + 7'd1;
        if ((r_sub == 2'd3) && !w_lastWord) begin
          r_w <= r_w + 4'd1;
        end
      end
    end
  end

  assign bus.tsr_rdy   = w_rdy;
  assign bus.dram_req  = w_req;
  assign bus.dram_addr = {w_pageSum, r_line[5:0], w_col};
  assign bus.ts_waddr  = r_x + {2'b00, r_p};
  assign bus.ts_wdata  = {r_pal, w_nibble};
  assign bus.ts_we     = w_draw && (w_nibble != 4'h0);

endmodule
